// File: rtl/barrel_shift_left_pipe_if.sv
// Operand/result handshake bundle for the pipelined left barrel shifter.
// master: the producer/consumer side (drives operands, accepts results).
// slave:  the shifter itself.
interface barrel_shift_left_pipe_if #(
  parameter int DATA_W = 64,
  parameter int SAMT_W = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] d_in;
  logic        [SAMT_W-1:0] samt;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] d_out;
  logic                     ovf;

  modport master (
    output in_valid, d_in, samt, out_ready,
    input  in_ready, out_valid, d_out, ovf
  );

  modport slave (
    input  in_valid, d_in, samt, out_ready,
    output in_ready, out_valid, d_out, ovf
  );
endinterface

// File: rtl/barrel_shift_left_pipe.sv
// Two-stage pipelined barrel left shifter with signed-overflow detection.
// Stage 1 applies the coarse shift bits (samt[SAMT_W-1:3], multiples of 8),
// stage 2 the fine bits (samt[2:0]). Each stage contributes an overflow term;
// the reported ovf is their OR.
// Optional feature macro: SHL_SAT_EN -- when defined, an overflowing result
// saturates to the most positive / most negative value according to the
// operand sign. Undefined (default): the wrapped shift result is returned.
module barrel_shift_left_pipe #(
  parameter int DATA_W = 64,
  parameter int SAMT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  barrel_shift_left_pipe_if.slave   bus
);

  // Coarse shift: applies samt bits 3 and up as a chain of 2^b shifts.
  function automatic logic [DATA_W-1:0] shift_hi(input logic [DATA_W-1:0] x,
                                                 input logic [SAMT_W-1:0] s);
    logic [DATA_W-1:0] r;
    r = x;
    for (int b = 3; b < SAMT_W; b++) begin
      if (s[b]) r = r << (1 << b);
    end
    return r;
  endfunction

  // Fine shift: applies samt bits 2..0.
  function automatic logic [DATA_W-1:0] shift_lo(input logic [DATA_W-1:0] x,
                                                 input logic [2:0] s);
    logic [DATA_W-1:0] r;
    r = x;
    for (int b = 0; b < 3; b++) begin
      if (s[b]) r = r << (1 << b);
    end
    return r;
  endfunction

  // A left shift by k overflows iff any of the top k+1 bits of the value
  // differ from the original sign; k=0 only inspects the sign bit itself.
  function automatic logic top_bits_differ(input logic [DATA_W-1:0] x,
                                           input logic sgn,
                                           input int k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if ((i >= DATA_W - 1 - k) && (x[i] != sgn)) r = 1'b1;
    end
    return r;
  endfunction

`ifdef SHL_SAT_EN
  // Clamp to the representable extreme on the side of the operand sign.
  function automatic logic [DATA_W-1:0] saturate(input logic sgn);
    return sgn ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  endfunction
`endif

  logic                     vld_p1;
  logic signed [DATA_W-1:0] d_p1;
  logic        [2:0]        samt_lo_p1;
  logic                     sign_p1;
  logic                     ovf_p1;

  logic                     vld_p2;
  logic signed [DATA_W-1:0] d_p2;
  logic                     ovf_p2;

  logic                     adv2;
  logic                     acc1;

  logic        [DATA_W-1:0] shl_p0;
  logic                     ovf_p0;
  logic        [DATA_W-1:0] shl_p1;
  logic                     ovf_p1_tot;
  logic        [DATA_W-1:0] res_p1;

  // Handshake: stage 2 advances when stage 1 holds data and the output
  // slot is free or being drained; stage 1 accepts when empty or advancing.
  assign adv2          = vld_p1 & (~vld_p2 | bus.out_ready);
  assign bus.in_ready  = rst_n & (~vld_p1 | adv2);
  assign acc1          = bus.in_valid & bus.in_ready;

  assign bus.out_valid = vld_p2;
  assign bus.d_out     = d_p2;
  assign bus.ovf       = ovf_p2;

  // Coarse shift and its overflow term, straight from the operand.
  always_comb begin
    shl_p0 = shift_hi(bus.d_in, bus.samt);
    ovf_p0 = top_bits_differ(bus.d_in, bus.d_in[DATA_W-1],
                             8 * int'(bus.samt[SAMT_W-1:3]));
  end

  // ---- stage 1 register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      d_p1       <= '0;
      samt_lo_p1 <= '0;
      sign_p1    <= 1'b0;
      ovf_p1     <= 1'b0;
    end else if (acc1) begin
      vld_p1     <= 1'b1;
      d_p1       <= shl_p0;
      samt_lo_p1 <= bus.samt[2:0];
      sign_p1    <= bus.d_in[DATA_W-1];
      ovf_p1     <= ovf_p0;
    end else if (adv2) begin
      vld_p1     <= 1'b0;
    end
  end

  // Fine shift; overflow is judged against the original operand sign so a
  // sign flip already caught in stage 1 stays flagged.
  always_comb begin
    shl_p1     = shift_lo(d_p1, samt_lo_p1);
    ovf_p1_tot = ovf_p1 | top_bits_differ(d_p1, sign_p1, int'(samt_lo_p1));
`ifdef SHL_SAT_EN
    res_p1     = ovf_p1_tot ? saturate(sign_p1) : shl_p1;
`else
    res_p1     = shl_p1;
`endif
  end

  // ---- stage 2 (output) register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      d_p2   <= '0;
      ovf_p2 <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= 1'b1;
      d_p2   <= res_p1;
      ovf_p2 <= ovf_p1_tot;
    end else if (bus.out_ready) begin
      vld_p2 <= 1'b0;
    end
  end

endmodule
